i2s_deserializer: RTL

//  Receives the codec ADC I2S stream (BCLK, ADCLRCK, ADCDAT) and converts it to parallel

---
 rtl/i2s_deserializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2s_deserializer.sv
// rtl/i2s_deserializer.sv - I2S ADC stream to parallel signed stereo sample pairs.
// Optional DESER_MONO_SUM_EN: both outputs carry the floor-halved L+R mono mix.
`timescale 1ns/1ps
module i2s_deserializer #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         BCLK,
  input  logic                         ADCLRCK,
  input  logic                         ADCDAT,
  output logic signed [DATA_WIDTH-1:0] leftSample,
  output logic signed [DATA_WIDTH-1:0] rightSample,
  output logic                         sampleValid,
  output logic                         frameError
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {HUNT, DELAY, SHIFT, PAD} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
  logic                   bclk_prev, lrck_prev;
  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_rise, lr_edge, lr_fall;

  state_t                 state, state_next;
  logic                   chan, chan_next;
  logic [CW-1:0]          cnt;
  logic [DATA_WIDTH-1:0]  shreg, shreg_nxt, left_hold;
  logic                   have_left, emit;
  logic                   shift_en, clr_cnt, store_left, emit_set, drop_left, err, resync;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;
  assign lr_edge   = lrck_s ^ lrck_prev;
  assign lr_fall   = lr_edge & ~lrck_s;
  assign shreg_nxt = {shreg[DATA_WIDTH-2:0], dat_s};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ADCDAT};
      bclk_prev <= bclk_s;
      lrck_prev <= lrck_s;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= HUNT;
      chan  <= 1'b0;
    end else begin
      state <= state_next;
      chan  <= chan_next;
    end
  end

  // Word-select edges are tracked every CLK; an edge coincident with bclkRise makes that rise the delay bit.
  always_comb begin
    state_next = state;
    chan_next  = chan;
    shift_en   = 1'b0;
    clr_cnt    = 1'b0;
    store_left = 1'b0;
    emit_set   = 1'b0;
    drop_left  = 1'b0;
    err        = 1'b0;
    resync     = 1'b0;
    case (state)
      HUNT:  if (lr_fall) resync = 1'b1;
      DELAY: begin
        if (lr_edge) begin
          err    = 1'b1;
          resync = 1'b1;
        end else if (bclk_rise) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (lr_edge) begin
          err    = 1'b1;
          resync = 1'b1;
        end else if (bclk_rise) begin
          shift_en = 1'b1;
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            state_next = PAD;
            if (!chan)          store_left = 1'b1;
            else if (have_left) emit_set   = 1'b1;
          end
        end
      end
      PAD:     if (lr_edge) resync = 1'b1;
      default: state_next = HUNT;
    endcase
    if (resync) begin
      chan_next  = lrck_s;
      clr_cnt    = 1'b1;
      state_next = bclk_rise ? SHIFT : DELAY;
      if (!lrck_s) drop_left = 1'b1;
    end
    if (err) drop_left = 1'b1;
  end

`ifdef DESER_MONO_SUM_EN
  logic [DATA_WIDTH:0]   mono_sum;
  logic [DATA_WIDTH-1:0] mono;
  assign mono_sum = {left_hold[DATA_WIDTH-1], left_hold} + {shreg[DATA_WIDTH-1], shreg};
  assign mono     = mono_sum[DATA_WIDTH:1];
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt         <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      have_left   <= 1'b0;
      emit        <= 1'b0;
      sampleValid <= 1'b0;
      frameError  <= 1'b0;
      leftSample  <= '0;
      rightSample <= '0;
    end else begin
      if (clr_cnt) begin
        cnt   <= '0;
        shreg <= '0;
      end else if (shift_en) begin
        shreg <= shreg_nxt;
        cnt   <= cnt + 1'b1;
      end
      if (store_left) left_hold <= shreg_nxt;
      if (drop_left || emit_set) have_left <= 1'b0;
      else if (store_left)       have_left <= 1'b1;
      if (err) frameError <= 1'b1;
      emit        <= emit_set;
      sampleValid <= emit;
      if (emit) begin
`ifdef DESER_MONO_SUM_EN
        leftSample  <= mono;
        rightSample <= mono;
`else
        leftSample  <= left_hold;
        rightSample <= shreg;
`endif
      end
    end
  end

endmodule
